// File: rtl/ef_sram_bridge.sv
// ef_sram_bridge: registers the fabric SRAM request toward the EF_SRAM macro and
// arbitrates it against a management request/acknowledge port (preload/readback).
// Fabric always wins; management is served only in fabric-idle cycles.
// Optional feature: define EF_SRAM_BRIDGE_TIMEOUT_EN to enable the pending-request
// timeout counter and the mgmt_err response path (otherwise mgmt_err is tied to 0).
// Ports:
//   UserCLK, Reset                 clock, asynchronous active-high reset
//   fab_ad/di/ben/en/r_wb, fab_do  fabric request and held read data
//   mgmt_req/we/ad/wdata/ben       management request, held until mgmt_ack
//   mgmt_ack/err/rdata             one-cycle completion, timeout flag, read data
//   sram_ad/di/ben/en/r_wb         registered macro inputs
//   sram_do                        macro read data, valid the cycle after sampling
module ef_sram_bridge #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          UserCLK,
    input  logic          Reset,
    input  logic [AW-1:0] fab_ad,
    input  logic [DW-1:0] fab_di,
    input  logic [DW-1:0] fab_ben,
    input  logic          fab_en,
    input  logic          fab_r_wb,
    output logic [DW-1:0] fab_do,
    input  logic          mgmt_req,
    input  logic          mgmt_we,
    input  logic [AW-1:0] mgmt_ad,
    input  logic [DW-1:0] mgmt_wdata,
    input  logic [DW-1:0] mgmt_ben,
    output logic          mgmt_ack,
    output logic          mgmt_err,
    output logic [DW-1:0] mgmt_rdata,
    output logic [AW-1:0] sram_ad,
    output logic [DW-1:0] sram_di,
    output logic [DW-1:0] sram_ben,
    output logic          sram_en,
    output logic          sram_r_wb,
    input  logic [DW-1:0] sram_do
);
    typedef enum logic [2:0] {IDLE, PEND, ISSUE, RDWAIT, ACK} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] sram_ad_q, sram_ad_d;
    logic [DW-1:0] sram_di_q, sram_di_d, sram_ben_q, sram_ben_d;
    logic sram_en_q, sram_en_d, sram_r_wb_q, sram_r_wb_d;
    logic [DW-1:0] fab_do_q, fab_do_d, mgmt_rdata_q, mgmt_rdata_d;
    // read tags: {valid, owner}, owner 1 = management
    logic [1:0] tag1_q, tag1_d, tag2_q, tag2_d;
    logic mg_go, tmo;

    // management gets the macro only in a fabric-idle cycle while pending
    assign mg_go = (state_q == PEND) && !fab_en;

`ifdef EF_SRAM_BRIDGE_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    // the cycle that would bring the lost-cycle count to TIMEOUT ends the wait
    assign tmo = (state_q == PEND) && fab_en && (cnt_q == CW'(TIMEOUT - 1));
    always_comb begin
        cnt_d = (state_q == IDLE) ? '0 : ((state_q == PEND) && fab_en) ? cnt_q + 1'b1 : cnt_q;
        err_d = (state_q == IDLE) ? 1'b0 : tmo ? 1'b1 : err_q;
    end
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign mgmt_err = (state_q == ACK) && err_q;
`else
    // never true: without the timeout feature PEND waits for a fabric-idle cycle
    assign tmo      = (TIMEOUT < 0);
    assign mgmt_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = mgmt_req ? PEND : IDLE;
            PEND:    state_d = !fab_en ? ISSUE : tmo ? ACK : PEND;
            ISSUE:   state_d = mgmt_we ? ACK : RDWAIT;
            RDWAIT:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sram_en_d    = fab_en | mg_go;
        sram_ad_d    = fab_en ? fab_ad   : mg_go ? mgmt_ad    : sram_ad_q;
        sram_di_d    = fab_en ? fab_di   : mg_go ? mgmt_wdata : sram_di_q;
        sram_ben_d   = fab_en ? fab_ben  : mg_go ? mgmt_ben   : sram_ben_q;
        sram_r_wb_d  = fab_en ? fab_r_wb : mg_go ? ~mgmt_we   : sram_r_wb_q;
        tag1_d       = {fab_en ? fab_r_wb : (mg_go & ~mgmt_we), ~fab_en};
        tag2_d       = tag1_q;
        fab_do_d     = (tag2_q == 2'b10) ? sram_do : fab_do_q;
        mgmt_rdata_d = (tag2_q == 2'b11) ? sram_do : mgmt_rdata_q;
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            sram_ad_q    <= '0;
            sram_di_q    <= '0;
            sram_ben_q   <= '0;
            sram_en_q    <= 1'b0;
            sram_r_wb_q  <= 1'b1;
            tag1_q       <= '0;
            tag2_q       <= '0;
            fab_do_q     <= '0;
            mgmt_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            sram_ad_q    <= sram_ad_d;
            sram_di_q    <= sram_di_d;
            sram_ben_q   <= sram_ben_d;
            sram_en_q    <= sram_en_d;
            sram_r_wb_q  <= sram_r_wb_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            fab_do_q     <= fab_do_d;
            mgmt_rdata_q <= mgmt_rdata_d;
        end
    end

    assign mgmt_ack   = (state_q == ACK);
    assign sram_ad    = sram_ad_q;
    assign sram_di    = sram_di_q;
    assign sram_ben   = sram_ben_q;
    assign sram_en    = sram_en_q;
    assign sram_r_wb  = sram_r_wb_q;
    assign fab_do     = fab_do_q;
    assign mgmt_rdata = mgmt_rdata_q;
endmodule
